jt12_dcrm: RTL and testbench

- DC-removal stage placed directly downstream of the per-channel sound accumulator.
- Consumes the accumulator's held sample (snd, updated at each zero pulse) and applies a first-order high-pass: y[n] = x[n] - x[n-1] + a*y[n-1], with a = 1 - 2^-K.
- Delivers a saturated DW-bit result with a one-cycle valid strobe to the output mixer / DAC interface.

---
 rtl/jt12_dcrm.sv | 124 ++++++++++++
 tb/tb_jt12_dcrm.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_dcrm.sv
// DC-removal high-pass stage after the channel accumulator: y[n] = x[n] - x[n-1] + a*y[n-1],
// a = 1 - 2^-K, with a saturated DW-bit output, a one-cycle valid strobe and a bypass mode.
module jt12_dcrm #(
  parameter int unsigned DW = 16,
  parameter int unsigned K  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 enable,
  input  logic signed [DW-1:0] din,
  input  logic                 din_valid,
  output logic signed [DW-1:0] dout,
  output logic                 dout_valid,
  output logic                 ovf
);

  localparam int unsigned AW = DW + K + 3;  // accumulator width, K fractional bits
  localparam int unsigned SW = AW + 2;      // headroom for the unsaturated sum

  localparam logic signed [AW-1:0] AccMax = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] AccMin = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [DW-1:0] OutMax = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] OutMin = {1'b1, {(DW-1){1'b0}}};

  logic                 accept;
  logic signed [DW:0]   d_q, d_d;
  logic signed [DW-1:0] x_prev_q, x_prev_d;
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_byp_q, s1_byp_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 ovf_q, ovf_d;

  logic signed [SW-1:0] acc_ext, shr_ext, d_ext, sum;
  logic signed [AW-1:0] acc_nx, y;
  logic                 y_fits;
  logic signed [DW-1:0] y_sat;

  assign accept = clk_en & din_valid;

  // Stage 1: first difference, or raw sample in bypass.
  always_comb begin
    d_d        = d_q;
    x_prev_d   = x_prev_q;
    s1_byp_d   = s1_byp_q;
    s1_valid_d = accept;
    if (accept) begin
      s1_byp_d = ~enable;
      if (enable) begin
        d_d      = {din[DW-1], din} - {x_prev_q[DW-1], x_prev_q};
        x_prev_d = din;
      end else begin
        d_d      = {din[DW-1], din};
        x_prev_d = '0;
      end
    end
  end

  // Stage 2: leaky integrator; a*acc done as acc - (acc >>> K).
  always_comb begin
    acc_ext = {{2{acc_q[AW-1]}}, acc_q};
    shr_ext = {{2{acc_q[AW-1]}}, (acc_q >>> K)};
    d_ext   = {{(SW-DW-1){d_q[DW]}}, d_q};
    sum     = acc_ext - shr_ext + (d_ext <<< K);
    if ((&sum[SW-1:AW-1]) | ~(|sum[SW-1:AW-1])) begin
      acc_nx = sum[AW-1:0];
    end else begin
      acc_nx = sum[SW-1] ? AccMin : AccMax;
    end
    y      = acc_nx >>> K;
    y_fits = (&y[AW-1:DW-1]) | ~(|y[AW-1:DW-1]);
    if (y_fits) begin
      y_sat = y[DW-1:0];
    end else begin
      y_sat = y[AW-1] ? OutMin : OutMax;
    end
  end

  always_comb begin
    acc_d        = acc_q;
    dout_d       = dout_q;
    ovf_d        = 1'b0;
    dout_valid_d = s1_valid_q;
    if (s1_valid_q) begin
      if (s1_byp_q) begin
        acc_d  = '0;
        dout_d = d_q[DW-1:0];
      end else begin
        acc_d  = acc_nx;
        dout_d = y_sat;
        ovf_d  = ~y_fits;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q          <= '0;
      x_prev_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_byp_q     <= 1'b0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      d_q          <= d_d;
      x_prev_q     <= x_prev_d;
      s1_valid_q   <= s1_valid_d;
      s1_byp_q     <= s1_byp_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_jt12_dcrm.sv
// Randomized and directed bench for jt12_dcrm against an arithmetic model of the filter.
module tb_jt12_dcrm;

  localparam int DW = 16;
  localparam int K  = 8;
  localparam int AW = DW + K + 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clk_en = 1'b0;
  logic                 enable = 1'b1;
  logic signed [DW-1:0] din = '0;
  logic                 din_valid = 1'b0;
  logic signed [DW-1:0] dout;
  logic                 dout_valid;
  logic                 ovf;

  jt12_dcrm #(.DW(DW), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .enable    (enable),
    .din       (din),
    .din_valid (din_valid),
    .dout      (dout),
    .dout_valid(dout_valid),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     due;
    longint val;
    bit     ovf;
  } exp_t;

  exp_t   exp_q[$];
  longint obs[$];
  bit     obs_ovf[$];
  int     cyc = 0;
  int     total = 0;
  int     bad = 0;
  longint hold = 0;
  longint m_xp = 0;
  longint m_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Floor division by 2^K.
  function automatic longint fdiv(input longint a);
    longint p = longint'(1) << K;
    return (a >= 0) ? a / p : -((-a + p - 1) / p);
  endfunction

  function automatic void model(input bit en, input longint x, input int due);
    exp_t   e;
    longint d, y;
    longint amax = (longint'(1) << (AW - 1)) - 1;
    longint amin = -(longint'(1) << (AW - 1));
    if (en) begin
      d     = x - m_xp;
      m_xp  = x;
      m_acc = m_acc - fdiv(m_acc) + d * (longint'(1) << K);
      if (m_acc > amax) m_acc = amax;
      if (m_acc < amin) m_acc = amin;
      y     = fdiv(m_acc);
      e.ovf = (y > 32767) || (y < -32768);
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
    end else begin
      m_xp  = 0;
      m_acc = 0;
      y     = x;
      e.ovf = 1'b0;
    end
    e.val = y;
    e.due = due;
    exp_q.push_back(e);
  endfunction

  task automatic step(input bit ce, input bit v, input bit en, input int d);
    longint xs;
    clk_en    = ce;
    din_valid = v;
    enable    = en;
    din       = d[DW-1:0];
    xs        = longint'(din);
    @(posedge clk);
    #1;
    if (ce && v) model(en, xs, cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 0);
  endtask

  // Scoreboard: every valid must match the next expected sample on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("latency", cyc, e.due);
          check("dout", dout, e.val);
          check("ovf", ovf, e.ovf);
          hold = e.val;
        end
        obs.push_back(dout);
        obs_ovf.push_back(ovf);
      end else begin
        check("ovf_idle", ovf, 0);
        check("dout_hold", dout, hold);
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          check("missing_valid", 0, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #12;
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    idle(2);

    // DC step: 1000 held, one accept every 4 clocks.
    obs.delete();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b1, 1'b1, 1000);
      idle(3);
    end
    check("dc_count", obs.size(), 300);
    if (obs.size() == 300) begin
      check("dc_first", obs[0], 1000);
      check("dc_second", obs[1], 996);
      check("dc_256", (obs[255] >= 365 && obs[255] <= 371), 1);
      for (int i = 1; i < 300; i++) check("dc_monotonic", (obs[i] <= obs[i-1] && obs[i] >= 0), 1);
    end

    // Overflow: clear state with a bypass sample, then full-scale swing.
    step(1'b1, 1'b1, 1'b0, 0);
    idle(3);
    obs.delete();
    obs_ovf.delete();
    step(1'b1, 1'b1, 1'b1, 32767);
    idle(3);
    step(1'b1, 1'b1, 1'b1, -32768);
    idle(3);
    check("ovf_count", obs.size(), 2);
    if (obs.size() == 2) begin
      check("ovf_first", obs[0], 32767);
      check("ovf_first_flag", obs_ovf[0], 0);
      check("ovf_second", obs[1], -32768);
      check("ovf_second_flag", obs_ovf[1], 1);
    end

    // Bypass on consecutive clocks, then re-enable.
    obs.delete();
    obs_ovf.delete();
    step(1'b1, 1'b1, 1'b0, 1234);
    step(1'b1, 1'b1, 1'b0, -5);
    step(1'b1, 1'b1, 1'b0, 32767);
    idle(3);
    step(1'b1, 1'b1, 1'b1, 500);
    idle(3);
    check("byp_count", obs.size(), 4);
    if (obs.size() == 4) begin
      check("byp_0", obs[0], 1234);
      check("byp_1", obs[1], -5);
      check("byp_2", obs[2], 32767);
      check("byp_ovf", obs_ovf[0] | obs_ovf[1] | obs_ovf[2], 0);
      check("reenable", obs[3], 500);
    end

    // Gating: din_valid without clk_en must be ignored.
    step(1'b1, 1'b1, 1'b0, 0);
    idle(3);
    obs.delete();
    step(1'b1, 1'b1, 1'b1, 100);
    idle(2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, int'($urandom_range(0, 65535)));
    step(1'b1, 1'b1, 1'b1, 100);
    idle(3);
    check("gate_count", obs.size(), 2);
    if (obs.size() == 2) begin
      check("gate_first", obs[0], 100);
      check("gate_decay", obs[1], 99);
    end

    // Back-to-back accepts.
    obs.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, int'($urandom_range(0, 65535)));
    idle(3);
    check("b2b_count", obs.size(), 8);

    // Random traffic, mode toggles and gaps.
    for (int i = 0; i < 400; i++) begin
      int v;
      case ($urandom_range(0, 5))
        0:       v = 32767;
        1:       v = -32768;
        default: v = int'($urandom_range(0, 65535));
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7) != 0, v);
    end
    idle(3);

    // Asynchronous reset with a sample sitting in stage 1.
    step(1'b1, 1'b1, 1'b1, 20000);
    idle(2);
    step(1'b1, 1'b1, 1'b1, -7000);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dout", dout, 0);
    check("mid_rst_valid", dout_valid, 0);
    check("mid_rst_ovf", ovf, 0);
    exp_q.delete();
    m_xp  = 0;
    m_acc = 0;
    hold  = 0;
    obs.delete();
    idle(2);
    rst_n = 1'b1;
    idle(5);
    check("post_rst_no_valid", obs.size(), 0);
    step(1'b1, 1'b1, 1'b1, 300);
    idle(3);
    check("post_rst_first", obs.size() == 1 ? obs[0] : -1, 300);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
